hamm_encoder_stream: RTL and testbench
======================================

# hamm_encoder_stream

- Registered Hamming(12,8) encoder with a valid/ready stream interface on both sides.
- Sits directly upstream of the hamm_decoder stage. Each accepted byte becomes a 12-bit codeword plus a separate overall-parity bit, in exactly the bit layout the decoder checks.
- An optional per-word error mask flips chosen codeword/parity bits, so single- and double-bit errors can be injected into the decoder path on purpose.
- A 2-entry elastic buffer (output register plus skid register) and two statistics counters make it sequential.

## Interface
- CNT_W, default 16: width of the statistics counters.
- clk, input, 1: clock; all logic is on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- in_data, input, 8: data byte.
- in_mask, input, 13: error mask sampled with in_data. Bits [11:0] are XORed into the codeword; bit [12] is XORed into the parity bit.
- in_valid, input, 1: upstream word valid.
- in_ready, output, 1: block can accept a word.
- out_code, output, 12: codeword; drives the decoder's IN.
- out_parity, output, 1: overall parity; drives the decoder's IN_PARITY.
- out_valid, output, 1: out_code/out_parity valid.
- out_ready, input, 1: downstream accepts.
- word_cnt, output, CNT_W: count of output handshakes.
- inj_cnt, output, CNT_W: count of output handshakes whose mask was non-zero.

## Operation
- Codeword layout, index i = Hamming position i+1:
  - Data: c[2]=d[0], c[6:4]=d[3:1], c[11:8]=d[7:4].
  - p1 = c[0] = c2^c4^c6^c8^c10.
  - p2 = c[1] = c2^c5^c6^c9^c10.
  - p4 = c[3] = c4^c5^c6^c11.
  - p8 = c[7] = c8^c9^c10^c11.
- Parity: parity = ^c[11:0], the even overall parity of the clean codeword.
- Stored word (13 bits): {parity ^ in_mask[12], c ^ in_mask[11:0]}, plus a 1-bit flag "mask non-zero". Encoding is combinational at input; the result is registered.
- Storage: OUT register (drives the outputs) and SKID register. Each has a valid flag.
- in_ready is a register and equals !skid_valid.
- Accept = in_valid & in_ready. Send = out_valid & out_ready.
- Per-cycle update, priority in order:
  1. Send and skid_valid: SKID moves to OUT. If accept, the new word goes to SKID; otherwise skid_valid clears.
  2. Send, no skid: on accept the new word loads OUT; otherwise out_valid clears.
  3. No send, accept: if !out_valid the word loads OUT; else it loads SKID (skid_valid sets, in_ready drops next cycle).
- Ordering is strict FIFO; no word is ever dropped or duplicated.
- Outputs hold stable while out_valid & !out_ready.
- Counters:
  - word_cnt increments by 1 on every Send.
  - inj_cnt increments by 1 on every Send whose flag is set.
  - Both wrap modulo 2^CNT_W with no saturation.

## Timing
- Reset values, applied on the clk edge where rst_n=0: out_code=0, out_parity=0, out_valid=0, in_ready=0, skid_valid=0, word_cnt=0, inj_cnt=0.
- in_ready rises on the first edge with rst_n=1.
- If rst_n goes low mid-operation, buffered words are discarded and all of the above take their reset values on that edge.
- Latency: a byte accepted at edge N appears on out_code after edge N (out_valid=1 in cycle N+1).
- Throughput: 1 word/cycle while out_ready=1.
- Backpressure: with out_ready=0, at most 2 words are buffered. in_ready deasserts the cycle after SKID fills and reasserts the cycle after SKID drains.
- Simultaneous Send and accept with buffer full: legal only when in_ready=1, i.e. never with SKID full. in_ready is registered, so it never depends combinationally on out_ready.
- in_mask takes effect only on the word accepted in the same cycle.

## Test plan
- Clean vectors, out_ready=1, in_mask=0:
  - 8'hA5 → out_code=12'hA27, out_parity=0.
  - 8'h00 → 12'h000, 0.
  - 8'hFF → 12'hF77, 0.
  - Each appears 1 cycle after accept; word_cnt=3, inj_cnt=0.
- Exhaustive loopback: all 256 bytes into the decoder with in_mask=0 → decoder out equals the byte, single_bit_error=0, double_bit_error=0.
- Injection: 8'hA5 with in_mask=13'h0004 → out_code=12'hA23, out_parity=0, decoder syndrome 3, out=8'hA5.
  - in_mask=13'h1000 → out_code=12'hA27, out_parity=1.
  - in_mask=13'h0005 → decoder double_bit_error=1.
  - inj_cnt increments once per masked word.
- Backpressure: out_ready=0, stream 8'h01, 8'h02, 8'h03 with in_valid held → two accepted, in_ready=0. Release out_ready → outputs encode 01, 02, 03 in order, no loss, word_cnt=3.
- Reset mid-stream: with both entries full, pulse rst_n=0 for one cycle → next cycle out_valid=0, in_ready=0, counters=0. The cycle after, in_ready=1 and no stale word is emitted.
- Counter wrap with CNT_W=4: 17 sends → word_cnt=1.

Source files
------------

// File: rtl/hamm_encoder_stream_if.sv
// Stream bundle for the Hamming encoder: byte+mask in, codeword+parity out.
// The master modport is the side that sources in_* and sinks out_*.
interface hamm_encoder_stream_if;
  logic [7:0]  in_data;
  logic [12:0] in_mask;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] out_code;
  logic        out_parity;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_mask, in_valid, out_ready,
    input  in_ready, out_code, out_parity, out_valid
  );

  modport slave (
    input  in_data, in_mask, in_valid, out_ready,
    output in_ready, out_code, out_parity, out_valid
  );
endinterface

// File: rtl/hamm_encoder_stream.sv
// Registered Hamming(12,8) encoder with error-mask injection, a two-entry
// elastic buffer (output + skid register) and send/injection counters.
module hamm_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hamm_encoder_stream_if.slave bus,
  output logic [CNT_W-1:0]     word_cnt,
  output logic [CNT_W-1:0]     inj_cnt
);

  logic [11:0] code_c;
  logic        parity_c;
  logic [12:0] new_word;
  logic        new_flag;

  logic [12:0] out_word, out_word_n;
  logic        out_flag, out_flag_n;
  logic        out_valid, out_valid_n;
  logic [12:0] skid_word, skid_word_n;
  logic        skid_flag, skid_flag_n;
  logic        skid_valid, skid_valid_n;
  logic        in_ready, in_ready_n;
  logic [CNT_W-1:0] word_cnt_n, inj_cnt_n;

  logic accept;
  logic send;

  // Bit layout must match the downstream decoder exactly (index i = position i+1).
  always_comb begin
    code_c       = '0;
    code_c[2]    = bus.in_data[0];
    code_c[6:4]  = bus.in_data[3:1];
    code_c[11:8] = bus.in_data[7:4];
    code_c[0]    = code_c[2] ^ code_c[4] ^ code_c[6] ^ code_c[8] ^ code_c[10];
    code_c[1]    = code_c[2] ^ code_c[5] ^ code_c[6] ^ code_c[9] ^ code_c[10];
    code_c[3]    = code_c[4] ^ code_c[5] ^ code_c[6] ^ code_c[11];
    code_c[7]    = code_c[8] ^ code_c[9] ^ code_c[10] ^ code_c[11];
    parity_c     = ^code_c;
    new_word     = {parity_c ^ bus.in_mask[12], code_c ^ bus.in_mask[11:0]};
    new_flag     = |bus.in_mask;
  end

  assign accept = bus.in_valid & in_ready;
  assign send   = out_valid & bus.out_ready;

  always_comb begin
    out_word_n   = out_word;
    out_flag_n   = out_flag;
    out_valid_n  = out_valid;
    skid_word_n  = skid_word;
    skid_flag_n  = skid_flag;
    skid_valid_n = skid_valid;
    word_cnt_n   = word_cnt;
    inj_cnt_n    = inj_cnt;

    if (send && skid_valid) begin
      out_word_n = skid_word;
      out_flag_n = skid_flag;
      if (accept) begin
        skid_word_n = new_word;
        skid_flag_n = new_flag;
      end else begin
        skid_valid_n = 1'b0;
      end
    end else if (send) begin
      if (accept) begin
        out_word_n = new_word;
        out_flag_n = new_flag;
      end else begin
        out_valid_n = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid) begin
        out_word_n  = new_word;
        out_flag_n  = new_flag;
        out_valid_n = 1'b1;
      end else begin
        skid_word_n  = new_word;
        skid_flag_n  = new_flag;
        skid_valid_n = 1'b1;
      end
    end

    if (send) begin
      word_cnt_n = word_cnt + CNT_W'(1);
      if (out_flag) begin
        inj_cnt_n = inj_cnt + CNT_W'(1);
      end
    end

    // Registering !skid_valid_n keeps in_ready free of any path from out_ready.
    in_ready_n = !skid_valid_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_word   <= '0;
      out_flag   <= 1'b0;
      out_valid  <= 1'b0;
      skid_word  <= '0;
      skid_flag  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
      word_cnt   <= '0;
      inj_cnt    <= '0;
    end else begin
      out_word   <= out_word_n;
      out_flag   <= out_flag_n;
      out_valid  <= out_valid_n;
      skid_word  <= skid_word_n;
      skid_flag  <= skid_flag_n;
      skid_valid <= skid_valid_n;
      in_ready   <= in_ready_n;
      word_cnt   <= word_cnt_n;
      inj_cnt    <= inj_cnt_n;
    end
  end

  assign bus.out_code   = out_word[11:0];
  assign bus.out_parity = out_word[12];
  assign bus.out_valid  = out_valid;
  assign bus.in_ready   = in_ready;

endmodule

// File: tb/tb_hamm_encoder_stream.sv
// Scoreboard bench for hamm_encoder_stream: directed vectors, injection,
// backpressure, mid-stream reset and counter wrap on a narrow-counter instance.
module tb_hamm_encoder_stream;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] code;
    logic        parity;
    int          kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] word_cnt, inj_cnt;
  logic [3:0]  word_cnt4, inj_cnt4;

  hamm_encoder_stream_if bus ();
  hamm_encoder_stream_if bus4 ();

  hamm_encoder_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .word_cnt(word_cnt), .inj_cnt(inj_cnt)
  );

  hamm_encoder_stream #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .word_cnt(word_cnt4), .inj_cnt(inj_cnt4)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Independent formulation: data fills non-power-of-two positions, each parity
  // covers the positions whose index has that bit set.
  function automatic logic [11:0] model_code(input logic [7:0] d);
    logic [11:0] c;
    int k;
    c = '0;
    k = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      for (int pos = 1; pos <= 12; pos++) begin
        if ((pos & p) != 0 && pos != p) c[p-1] = c[p-1] ^ c[pos-1];
      end
    end
    return c;
  endfunction

  // Reference decoder: returns error class (0 clean, 1 single, 2 double) and data.
  task automatic model_decode(input logic [11:0] code, input logic parity,
                              output int kind, output logic [7:0] data);
    int syn;
    logic overall;
    logic [11:0] c;
    syn = 0;
    c = code;
    for (int i = 0; i < 12; i++) if (code[i]) syn = syn ^ (i + 1);
    overall = (^code) ^ parity;
    if (syn == 0 && !overall) kind = 0;
    else if (overall) kind = 1;
    else kind = 2;
    if (overall && syn != 0 && syn <= 12) c[syn-1] = ~c[syn-1];
    data = {c[11:8], c[6:4], c[2]};
  endtask

  always @(negedge clk) begin
    exp_t e;
    int kind;
    logic [7:0] dec;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("[TB] FAIL unexpected_word: got code 0x%0h, expected no word", bus.out_code);
      end else begin
        e = exp_q.pop_front();
        check_output("out_code", {20'd0, bus.out_code}, {20'd0, e.code});
        check_output("out_parity", {31'd0, bus.out_parity}, {31'd0, e.parity});
        model_decode(bus.out_code, bus.out_parity, kind, dec);
        check_output("decode_class", kind, e.kind);
        if (e.kind != 2) check_output("decode_data", {24'd0, dec}, {24'd0, e.data});
      end
    end
  end

  // Drives one word from posedge+1 and waits (bounded) for its accept edge.
  task automatic apply_stimulus(input logic [7:0] data, input logic [12:0] mask,
                                input logic [11:0] code, input logic parity, input int kind);
    exp_t e;
    bit done;
    done = 0;
    bus.in_data  = data;
    bus.in_mask  = mask;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.data = data; e.code = code; e.parity = parity; e.kind = kind;
        exp_q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_mask  = '0;
    if (!done) begin
      errors++;
      checks++;
      $display("[TB] FAIL accept_timeout: data 0x%0h not accepted, expected accept", data);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int accepted;
    logic [11:0] mc;
    bus.in_data = '0; bus.in_mask = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus4.in_data = '0; bus4.in_mask = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;

    idle(2);
    check_output("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check_output("rst_in_ready", {31'd0, bus.in_ready}, 0);
    check_output("rst_out_code", {20'd0, bus.out_code}, 0);
    check_output("rst_word_cnt", {16'd0, word_cnt}, 0);
    check_output("rst_inj_cnt", {16'd0, inj_cnt}, 0);
    rst_n = 1'b1;
    idle(1);
    check_output("ready_after_rst", {31'd0, bus.in_ready}, 1);

    // Clean directed vectors with one-cycle latency check on the first.
    bus.out_ready = 1'b1;
    apply_stimulus(8'hA5, 13'h0000, 12'hA27, 1'b0, 0);
    check_output("latency_valid", {31'd0, bus.out_valid}, 1);
    check_output("latency_code", {20'd0, bus.out_code}, 32'hA27);
    apply_stimulus(8'h00, 13'h0000, 12'h000, 1'b0, 0);
    apply_stimulus(8'hFF, 13'h0000, 12'hF77, 1'b0, 0);
    idle(3);
    check_output("clean_word_cnt", {16'd0, word_cnt}, 3);
    check_output("clean_inj_cnt", {16'd0, inj_cnt}, 0);

    // Error injection: single data bit, parity bit only, double bit.
    apply_stimulus(8'hA5, 13'h0004, 12'hA23, 1'b0, 1);
    apply_stimulus(8'hA5, 13'h1000, 12'hA27, 1'b1, 1);
    apply_stimulus(8'hA5, 13'h0005, 12'hA22, 1'b0, 2);
    idle(3);
    check_output("inj_inj_cnt", {16'd0, inj_cnt}, 3);
    check_output("inj_word_cnt", {16'd0, word_cnt}, 6);

    // Backpressure: two words fill the buffer, the third waits.
    bus.out_ready = 1'b0;
    apply_stimulus(8'h01, 13'h0000, 12'h007, 1'b1, 0);
    apply_stimulus(8'h02, 13'h0000, 12'h019, 1'b1, 0);
    fork
      apply_stimulus(8'h03, 13'h0000, 12'h01E, 1'b0, 0);
      begin
        repeat (3) @(negedge clk);
        check_output("bp_in_ready", {31'd0, bus.in_ready}, 0);
        check_output("bp_hold_code", {20'd0, bus.out_code}, 32'h007);
        check_output("bp_hold_valid", {31'd0, bus.out_valid}, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(4);
    check_output("bp_word_cnt", {16'd0, word_cnt}, 9);

    for (int b = 0; b < 256; b++) begin
      mc = model_code(8'(b));
      apply_stimulus(8'(b), 13'h0000, mc, ^mc, 0);
    end
    idle(4);
    check_output("loop_word_cnt", {16'd0, word_cnt}, 265);

    // Mid-stream reset with both entries occupied.
    bus.out_ready = 1'b0;
    mc = model_code(8'h11);
    apply_stimulus(8'h11, 13'h0000, mc, ^mc, 0);
    mc = model_code(8'h22);
    apply_stimulus(8'h22, 13'h0000, mc, ^mc, 0);
    rst_n = 1'b0;
    exp_q.delete();
    idle(1);
    rst_n = 1'b1;
    check_output("mid_rst_valid", {31'd0, bus.out_valid}, 0);
    check_output("mid_rst_ready", {31'd0, bus.in_ready}, 0);
    check_output("mid_rst_word_cnt", {16'd0, word_cnt}, 0);
    check_output("mid_rst_inj_cnt", {16'd0, inj_cnt}, 0);
    bus.out_ready = 1'b1;
    idle(1);
    check_output("post_rst_ready", {31'd0, bus.in_ready}, 1);
    idle(3);
    check_output("no_stale_word", {31'd0, bus.out_valid}, 0);

    // Narrow counters: 17 masked sends wrap both 4-bit counters to 1.
    bus4.out_ready = 1'b1;
    bus4.in_mask   = 13'h0001;
    bus4.in_valid  = 1'b1;
    accepted = 0;
    for (int n = 0; n < 60 && accepted < 17; n++) begin
      bus4.in_data = 8'(accepted);
      @(negedge clk);
      if (bus4.in_ready) accepted++;
      @(posedge clk);
      #1;
    end
    bus4.in_valid = 1'b0;
    idle(4);
    check_output("wrap_accepted", accepted, 17);
    check_output("wrap_word_cnt", {28'd0, word_cnt4}, 1);
    check_output("wrap_inj_cnt", {28'd0, inj_cnt4}, 1);

    check_output("pending_words", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
